// File: rtl/rf_window_sequencer.sv
// rtl/rf_window_sequencer.sv - streams conv receptive-field windows, P lanes per beat
// Optional zero "same" padding is enabled by defining RF_SAME_PAD_EN.
module rf_window_sequencer #(
    parameter int DATA_WIDTH = 16,
    parameter int D          = 1,
    parameter int H          = 32,
    parameter int W          = 32,
    parameter int F          = 5,
    parameter int S          = 1,
    parameter int P          = 14
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [D*H*W*DATA_WIDTH-1:0]    image,
    input  logic                           start,
    input  logic                           outReady,
    output logic [P*D*F*F*DATA_WIDTH-1:0]  receptiveField,
    output logic [P-1:0]                   laneMask,
    output logic                           rfValid,
    output logic [10:0]                    outRow,
    output logic [10:0]                    outCol,
    output logic                           lastBeat,
    output logic                           busy,
    output logic                           done
);

`ifdef RF_SAME_PAD_EN
    localparam int PAD = (F - 1) / 2;
`else
    localparam int PAD = 0;
`endif
    localparam int OH      = (H + 2*PAD - F) / S + 1;
    localparam int OW      = (W + 2*PAD - F) / S + 1;
    localparam int BPR     = (OW + P - 1) / P;
    localparam int LAST_CB = (BPR - 1) * P;
    localparam int IMG_W   = D*H*W*DATA_WIDTH;
    localparam int RF_W    = P*D*F*F*DATA_WIDTH;
    localparam int IMG_AW  = $clog2(IMG_W);
    localparam int RF_AW   = $clog2(RF_W);

    typedef enum logic [1:0] {ST_IDLE, ST_EMIT, ST_DONE} state_t;

    state_t            state_q, state_d;
    logic [10:0]       r_q, r_d, cb_q, cb_d;
    logic [RF_W-1:0]   rf_q, rf_d, win;
    logic [P-1:0]      mask_q, mask_d, win_mask;
    logic              rfv_q, rfv_d, last_q, last_d, busy_q, busy_d, done_q, done_d;
    logic [10:0]       nr, ncb;
    logic              wrap, load;
    int                y, x;
    logic [IMG_AW-1:0] px_base;
    logic [RF_AW-1:0]  el_base;

    // Position of the beat that would be registered at the next load.
    assign wrap = (int'(cb_q) + P >= OW);

    always_comb begin
        nr  = '0;
        ncb = '0;
        if (state_q == ST_EMIT) begin
            if (wrap) begin
                nr  = r_q + 11'd1;
                ncb = '0;
            end else begin
                nr  = r_q;
                ncb = cb_q + 11'(P);
            end
        end
    end

    // Gather the P windows for (nr, ncb); lanes past the last output column stay zero.
    always_comb begin
        win      = '0;
        win_mask = '0;
        y        = 0;
        x        = 0;
        px_base  = '0;
        el_base  = '0;
        for (int p = 0; p < P; p++) begin
            if (int'(ncb) + p < OW) begin
                win_mask[p] = 1'b1;
                for (int k = 0; k < D; k++) begin
                    for (int i = 0; i < F; i++) begin
                        for (int j = 0; j < F; j++) begin
                            y       = int'(nr) * S + i - PAD;
                            x       = (int'(ncb) + p) * S + j - PAD;
                            px_base = IMG_AW'(((k*H + y)*W + x) * DATA_WIDTH);
                            el_base = RF_AW'((((p*D + k)*F + i)*F + j) * DATA_WIDTH);
`ifdef RF_SAME_PAD_EN
                            if (y >= 0 && y < H && x >= 0 && x < W)
`endif
                                win[el_base +: DATA_WIDTH] = image[px_base +: DATA_WIDTH];
                        end
                    end
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        rf_d    = rf_q;
        mask_d  = mask_q;
        r_d     = r_q;
        cb_d    = cb_q;
        rfv_d   = rfv_q;
        last_d  = last_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        load    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_EMIT;
                    load    = 1'b1;
                    rfv_d   = 1'b1;
                    busy_d  = 1'b1;
                end
            end
            ST_EMIT: begin
                if (rfv_q && outReady) begin
                    if (last_q) begin
                        state_d = ST_DONE;
                        rfv_d   = 1'b0;
                        mask_d  = '0;
                        last_d  = 1'b0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        load = 1'b1;
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        if (load) begin
            rf_d   = win;
            mask_d = win_mask;
            r_d    = nr;
            cb_d   = ncb;
            last_d = (int'(nr) == OH - 1) && (int'(ncb) == LAST_CB);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            rf_q    <= '0;
            mask_q  <= '0;
            r_q     <= '0;
            cb_q    <= '0;
            rfv_q   <= 1'b0;
            last_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rf_q    <= rf_d;
            mask_q  <= mask_d;
            r_q     <= r_d;
            cb_q    <= cb_d;
            rfv_q   <= rfv_d;
            last_q  <= last_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign receptiveField = rf_q;
    assign laneMask       = mask_q;
    assign rfValid        = rfv_q;
    assign outRow         = r_q;
    assign outCol         = cb_q;
    assign lastBeat       = last_q;
    assign busy           = busy_q;
    assign done           = done_q;

endmodule
